adc_temp_sampler: RTL and testbench



---
 rtl/adc_temp_sampler.sv | 209 ++++++++++++++++++++
 tb/tb_adc_temp_sampler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_temp_sampler.sv
// Sequencer for a 12-bit serial ADC: periodic bursts of conversions, config word out,
// sample in, and a truncated average of 2^AVG_LOG2 samples presented on adc_dout.
module adc_temp_sampler #(
    parameter int          CLK_DIV       = 2,
    parameter int          CONV_CYCLES   = 80,
    parameter int          SAMPLE_PERIOD = 50000,
    parameter int          AVG_LOG2      = 2,
    parameter logic [5:0]  CFG           = 6'b100010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_sdo,
    output logic        adc_convst,
    output logic        adc_sclk,
    output logic        adc_din,
    output logic [11:0] adc_dout,
    output logic        dout_valid,
    output logic        busy
);

    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int AW = 12 + AVG_LOG2;
    localparam logic [TW-1:0] TIMER_LAST  = TW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [4:0]    SAMPLE_LAST = 5'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV   = 3'd1,
        GAP    = 3'd2,
        SHIFT  = 3'd3,
        ACCUM  = 3'd4,
        UPDATE = 3'd5
    } state_t;

    state_t          state_r, next_state_s;
    logic [TW-1:0]   timer_r;
    logic            start_req_r;
    logic [CW-1:0]   conv_cnt_r;
    logic [DW-1:0]   div_cnt_r;
    logic [3:0]      bit_cnt_r;
    logic [11:0]     shift_r;
    logic [AW-1:0]   acc_r;
    logic [4:0]      sample_cnt_r;
    logic            convst_r, sclk_r, din_r, valid_r, busy_r;
    logic [11:0]     dout_r;

    logic            div_wrap_s, last_bit_s, last_sample_s, update_s;
    logic            sclk_next_s, din_next_s;
    logic [AW-1:0]   acc_sum_s;

    // Bit k of the 12-bit frame sent on adc_din: the config word MSB first, then zeros.
    function automatic logic cfg_bit(input logic [3:0] k);
        logic b;
        if (k < 4'd6) begin
            b = CFG[3'd5 - k[2:0]];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    assign div_wrap_s    = (div_cnt_r == DIV_LAST);
    assign last_bit_s    = (bit_cnt_r == 4'd11);
    assign last_sample_s = (sample_cnt_r == SAMPLE_LAST);
    assign acc_sum_s     = acc_r + AW'(shift_r);
    assign update_s      = (state_r == ACCUM) && last_sample_s;

    // Next-state decode for the conversion sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (start_req_r) next_state_s = CONV; else next_state_s = IDLE;
            CONV:    if (conv_cnt_r == CONV_LAST) next_state_s = GAP; else next_state_s = CONV;
            GAP:     next_state_s = SHIFT;
            SHIFT:   if (div_wrap_s && sclk_r && last_bit_s) next_state_s = ACCUM;
                     else next_state_s = SHIFT;
            ACCUM:   if (last_sample_s) next_state_s = UPDATE; else next_state_s = CONV;
            UPDATE:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the serial lines; din changes only as sclk falls into a low phase.
    always_comb begin
        sclk_next_s = 1'b0;
        din_next_s  = 1'b0;
        case (state_r)
            GAP: begin
                sclk_next_s = 1'b0;
                din_next_s  = cfg_bit(4'd0);
            end
            SHIFT: begin
                if (div_wrap_s) begin
                    sclk_next_s = ~sclk_r;
                end else begin
                    sclk_next_s = sclk_r;
                end
                if (div_wrap_s && sclk_r) begin
                    if (last_bit_s) din_next_s = 1'b0;
                    else din_next_s = cfg_bit(bit_cnt_r + 4'd1);
                end else begin
                    din_next_s = din_r;
                end
            end
            default: begin
                sclk_next_s = 1'b0;
                din_next_s  = 1'b0;
            end
        endcase
    end

    // Period timer; a wrap leaves a request pending until IDLE consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r     <= '0;
            start_req_r <= 1'b0;
        end else if (!enable) begin
            timer_r     <= '0;
            start_req_r <= 1'b0;
        end else begin
            if (timer_r == TIMER_LAST) timer_r <= '0;
            else timer_r <= timer_r + TW'(1'b1);
            if (timer_r == TIMER_LAST) start_req_r <= 1'b1;
            else if (state_r == IDLE && start_req_r) start_req_r <= 1'b0;
            else start_req_r <= start_req_r;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else state_r <= next_state_s;
    end

    // Phase counters, receive shift register and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt_r   <= '0;
            div_cnt_r    <= '0;
            bit_cnt_r    <= 4'd0;
            shift_r      <= 12'd0;
            acc_r        <= '0;
            sample_cnt_r <= 5'd0;
        end else begin
            case (state_r)
                CONV: begin
                    if (conv_cnt_r == CONV_LAST) conv_cnt_r <= '0;
                    else conv_cnt_r <= conv_cnt_r + CW'(1'b1);
                end
                GAP: begin
                    div_cnt_r <= '0;
                    bit_cnt_r <= 4'd0;
                end
                SHIFT: begin
                    if (div_wrap_s) begin
                        div_cnt_r <= '0;
                        if (!sclk_r) shift_r <= {shift_r[10:0], adc_sdo};
                        else if (!last_bit_s) bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1'b1);
                    end
                end
                ACCUM: begin
                    acc_r        <= acc_sum_s;
                    sample_cnt_r <= sample_cnt_r + 5'd1;
                end
                UPDATE: begin
                    acc_r        <= '0;
                    sample_cnt_r <= 5'd0;
                end
                default: begin
                    conv_cnt_r <= conv_cnt_r;
                end
            endcase
        end
    end

    // Registered outputs; the average is latched on leaving the last ACCUM so it shows during UPDATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            convst_r <= 1'b0;
            sclk_r   <= 1'b0;
            din_r    <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            dout_r   <= 12'd4095;
        end else begin
            convst_r <= (next_state_s == CONV);
            busy_r   <= (next_state_s != IDLE);
            sclk_r   <= sclk_next_s;
            din_r    <= din_next_s;
            valid_r  <= update_s;
            if (update_s) dout_r <= acc_sum_s[AW-1:AVG_LOG2];
        end
    end

    assign adc_convst = convst_r;
    assign adc_sclk   = sclk_r;
    assign adc_din    = din_r;
    assign adc_dout   = dout_r;
    assign dout_valid = valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_adc_temp_sampler.sv
// Directed bench: three sampler instances (normal, overrun, no averaging) with an ADC
// model each, a line monitor per instance, and hand-computed expected results.
module tb_adc_temp_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0]        en, sdo, convst, sclk, din, valid, busy;
    logic [2:0][11:0]  dout;
    logic [11:0]       samp [3][4];

    int total = 0, bad = 0;

    int cs_len[3], sk_hi[3], sk_lo[3], rises[3], err[3], conv_rises[3];
    int valids[3], conv_at_v[3], burst_convs[3], v_len[3], in_frame[3];
    int last_v[3], prev_v[3];
    logic [11:0] dword[3], vdout[3];
    logic cs_p[3], sk_p[3], v_p[3];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        logic        sdo_q, cs_q, sk_q;
        logic [11:0] cur_q;
        int          k_q;

        adc_temp_sampler #(
            .CLK_DIV(2), .CONV_CYCLES(4),
            .SAMPLE_PERIOD(g == 1 ? 50 : 300),
            .AVG_LOG2(g == 2 ? 0 : 2),
            .CFG(6'b100010)
        ) dut (
            .clk(clk), .rst(rst), .enable(en[g]), .adc_sdo(sdo_q),
            .adc_convst(convst[g]), .adc_sclk(sclk[g]), .adc_din(din[g]),
            .adc_dout(dout[g]), .dout_valid(valid[g]), .busy(busy[g])
        );

        assign sdo[g] = sdo_q;

        // ADC model: loads a sample when convst falls, presents the next bit after each sclk fall.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cs_q <= 1'b0; sk_q <= 1'b0; cur_q <= 12'd0; k_q <= 0; sdo_q <= 1'b0;
            end else begin
                cs_q <= convst[g];
                sk_q <= sclk[g];
                if (cs_q && !convst[g]) begin
                    cur_q <= {samp[g][k_q % 4][10:0], 1'b0};
                    sdo_q <= samp[g][k_q % 4][11];
                    k_q   <= k_q + 1;
                end else if (sk_q && !sclk[g]) begin
                    sdo_q <= cur_q[11];
                    cur_q <= {cur_q[10:0], 1'b0};
                end
            end
        end

        // Line monitor: frame shape, din word, pulse widths and burst bookkeeping.
        initial begin
            forever begin
                @(negedge clk);
                if (rst) begin
                    cs_len[g] = 0; sk_hi[g] = 0; sk_lo[g] = 0; rises[g] = 0; v_len[g] = 0;
                    in_frame[g] = 0; dword[g] = 12'd0; conv_at_v[g] = conv_rises[g];
                    cs_p[g] = 1'b0; sk_p[g] = 1'b0; v_p[g] = 1'b0;
                end else begin
                    if (convst[g] && sclk[g]) err[g]++;
                    if (convst[g] && !cs_p[g]) begin
                        if (in_frame[g] != 0 && (rises[g] != 12 || dword[g] != 12'h880)) err[g]++;
                        in_frame[g] = 1; rises[g] = 0; dword[g] = 12'd0; conv_rises[g]++;
                    end
                    if (!convst[g] && cs_p[g]) begin
                        if (cs_len[g] != 4) err[g]++;
                        cs_len[g] = 0;
                    end
                    if (convst[g]) cs_len[g]++;
                    if (sclk[g] && !sk_p[g]) begin
                        if (rises[g] > 0 && sk_lo[g] != 2) err[g]++;
                        rises[g]++;
                        dword[g] = {dword[g][10:0], din[g]};
                        sk_lo[g] = 0;
                    end
                    if (!sclk[g] && sk_p[g]) begin
                        if (sk_hi[g] != 2) err[g]++;
                        sk_hi[g] = 0;
                    end
                    if (sclk[g]) sk_hi[g]++; else sk_lo[g]++;
                    if (valid[g] && !v_p[g]) begin
                        if (in_frame[g] == 0 || rises[g] != 12 || dword[g] != 12'h880) err[g]++;
                        in_frame[g] = 0;
                        valids[g]++;
                        prev_v[g] = last_v[g];
                        last_v[g] = int'($time / 10);
                        burst_convs[g] = conv_rises[g] - conv_at_v[g];
                        conv_at_v[g] = conv_rises[g];
                        vdout[g] = dout[g];
                    end
                    if (!valid[g] && v_p[g]) begin
                        if (v_len[g] != 1) err[g]++;
                        v_len[g] = 0;
                    end
                    if (valid[g]) v_len[g]++;
                    cs_p[g] = convst[g]; sk_p[g] = sclk[g]; v_p[g] = valid[g];
                end
            end
        end
    end

    task automatic wait_valid(input int g, input int budget, input string tag);
        int n0, t;
        n0 = valids[g];
        t  = 0;
        while (valids[g] == n0 && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check(tag, (valids[g] != n0) ? 1 : 0, 1);
    endtask

    initial begin
        int r0, n0, t;
        rst = 1'b1;
        en  = 3'b000;
        samp[0] = '{12'd3550, 12'd3550, 12'd3550, 12'd3550};
        samp[1] = '{12'd1000, 12'd1000, 12'd1000, 12'd1000};
        samp[2] = '{12'd3666, 12'd3666, 12'd3666, 12'd3666};

        @(negedge clk); #1;
        check("rst_dout", dout[0], 4095);
        check("rst_ctrl", {convst[0], sclk[0], din[0], valid[0], busy[0]}, 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (400) @(negedge clk);
        #1;
        check("dis_no_convst", conv_rises[0] + conv_rises[1] + conv_rises[2], 0);
        check("dis_idle", busy, 0);

        en = 3'b111;
        wait_valid(0, 1000, "const_seen1");
        check("const_dout1", vdout[0], 3550);
        check("const_convs", burst_convs[0], 4);
        wait_valid(0, 400, "const_seen2");
        check("const_dout2", vdout[0], 3550);
        check("const_period", last_v[0] - prev_v[0], 300);

        check("ovr_dout", vdout[1], 1000);
        check("ovr_convs", burst_convs[1], 4);
        check("ovr_period", last_v[1] - prev_v[1], 218);
        check("ovr_count3", (valids[1] >= 3) ? 1 : 0, 1);
        check("a0_dout", vdout[2], 3666);
        check("a0_convs", burst_convs[2], 1);
        check("a0_period", last_v[2] - prev_v[2], 300);

        samp[0] = '{12'd3550, 12'd3576, 12'd3595, 12'd3625};
        wait_valid(0, 400, "avg_seen");
        check("avg_dout", vdout[0], 3586);
        check("avg_convs", burst_convs[0], 4);

        r0 = conv_rises[0];
        t = 0;
        while (conv_rises[0] < r0 + 2 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("endrop_conv2", conv_rises[0] - r0, 2);
        en[0] = 1'b0;
        wait_valid(0, 300, "endrop_seen");
        check("endrop_dout", vdout[0], 3586);
        check("endrop_convs", burst_convs[0], 4);
        r0 = conv_rises[0];
        n0 = valids[0];
        repeat (700) @(negedge clk);
        #1;
        check("endrop_no_conv", conv_rises[0] - r0, 0);
        check("endrop_no_valid", valids[0] - n0, 0);
        check("endrop_idle", busy[0], 0);

        en[0] = 1'b1;
        t = 0;
        while (!(rises[0] == 8 && sclk[0] == 1'b1) && t < 600) begin
            @(negedge clk); #1;
            t++;
        end
        check("midrst_bit7_high", sclk[0], 1);
        rst = 1'b1;
        #1;
        check("midrst_sclk", sclk[0], 0);
        check("midrst_convst", convst[0], 0);
        check("midrst_dout", dout[0], 4095);
        check("midrst_ctrl", {din[0], valid[0], busy[0]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(0, 800, "restart_seen");
        check("restart_dout", vdout[0], 3586);
        check("restart_convs", burst_convs[0], 4);

        check("frame_err0", err[0], 0);
        check("frame_err1", err[1], 0);
        check("frame_err2", err[2], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
